sync_stage_fifo: RTL
====================

// Module: sync_stage_fifo
// PURPOSE
//  Single-clock, parametrised successor of the one-entry token stage: DEPTH-entry
//  show-ahead buffer with writex/wfull and readx/rempty handshakes, occupancy count,
//  almost-full flag and sticky overflow/underflow error flags. Used between pipeline
//  stages in the same clock domain where one entry of elasticity is not enough.
// PARAMETERS
//  WID    32        data width in bits
//  DEPTH  4         number of entries; power of two, >= 2
//  AFULL  DEPTH-1   afull asserts when count >= AFULL; legal range 1..DEPTH
// PORTS
//  clk      in   1                clock, all logic on posedge
//  rst      in   1                synchronous reset, active high
//  writex   in   1                write request; accepted when wacc=1 (see BEHAVIOUR)
//  wdata    in   WID              write data, sampled on accepted write
//  wfull    out  1                count==DEPTH
//  afull    out  1                count>=AFULL
//  readx    in   1                read request; accepted when !rempty
//  rdata    out  WID              head entry, valid whenever !rempty (show-ahead)
//  rempty   out  1                count==0
//  count    out  $clog2(DEPTH+1)  current occupancy 0..DEPTH
//  ovf_err  out  1                sticky: writex while write refused
//  udf_err  out  1                sticky: readx while rempty
//  clr_err  in   1                clears ovf_err/udf_err on next edge
// BEHAVIOUR
//  - Storage: DEPTH x WID register array; wptr/rptr are $clog2(DEPTH)-bit, wrap mod DEPTH.
//  - racc = readx && !rempty.  wacc = writex && (!wfull || racc).
//    Write into full buffer is accepted only when a read is accepted in the same cycle.
//  - Accepted write: mem[wptr]<=wdata, wptr<=wptr+1. Accepted read: rptr<=rptr+1.
//  - count next = count + wacc - racc; both accepted -> count unchanged.
//  - Empty + writex + readx: read refused (udf_err sets), write accepted, count->1.
//  - rdata = mem[rptr] combinational from array; write-to-read latency 1 cycle
//    (data written at edge N is on rdata and rempty=0 after edge N). No bypass.
//  - rdata undefined-but-stable (last mem value) when rempty; bench must not check it.
//  - wfull/rempty/afull decoded from registered count; no combinational path from
//    writex/readx to any flag.
//  - ovf_err <= 1 on writex && !wacc; udf_err <= 1 on readx && rempty.
//    clr_err has priority over setting in the same cycle (cleared, event lost).
//  - Reset (rst=1 at edge): wptr=rptr=0, count=0, rempty=1, wfull=0, afull=0,
//    ovf_err=udf_err=0. Array contents NOT reset. Reset mid-operation discards all
//    entries; requests in the reset cycle are ignored and flag no errors.
//  - Pointer wrap: after DEPTH accepted writes wptr returns to 0; ordering preserved
//    across wrap (strict FIFO).
// TESTING
//  1 Reset, then write 0xA0..0xA3 (DEPTH=4) on 4 cycles -> count 1,2,3,4; afull at 3;
//    wfull at 4; rempty=0 after first edge, rdata=0xA0.
//  2 Full, writex=1 readx=0 wdata=0xBB -> refused, count stays 4, ovf_err=1;
//    clr_err pulse -> ovf_err=0 next cycle.
//  3 Full, writex=1 readx=1 wdata=0xCC -> both accepted, count=4, rdata=0xA1;
//    drain 4 reads -> 0xA1,0xA2,0xA3,0xCC then rempty=1.
//  4 Empty, writex=1 readx=1 wdata=0x11 -> count=1, udf_err=1, rdata=0x11.
//  5 Stream 3*DEPTH+1 values with random readx/writex -> scoreboard order exact,
//    count never >DEPTH or <0, pointers wrap cleanly.
//  6 rst asserted with count=3 and writex/readx high -> count=0, rempty=1, no err flags;
//    first post-reset write appears on rdata next cycle.

Source files
------------

// File: rtl/sync_stage_fifo_if.sv
// Handshake bundle for sync_stage_fifo: producer write side, consumer read side,
// status flags and sticky error flags with their clear strobe.
interface sync_stage_fifo_if #(
  parameter int WID   = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic           writex;
  logic [WID-1:0] wdata;
  logic           wfull;
  logic           afull;
  logic           readx;
  logic [WID-1:0] rdata;
  logic           rempty;
  logic [CW-1:0]  count;
  logic           ovf_err;
  logic           udf_err;
  logic           clr_err;

  // Pipeline-side user of the buffer
  modport master (
    output writex, wdata, readx, clr_err,
    input  wfull, afull, rdata, rempty, count, ovf_err, udf_err
  );

  // The buffer itself
  modport slave (
    input  writex, wdata, readx, clr_err,
    output wfull, afull, rdata, rempty, count, ovf_err, udf_err
  );
endinterface

// File: rtl/sync_stage_fifo.sv
// DEPTH-entry show-ahead FIFO for same-clock pipeline stages, with occupancy count,
// almost-full flag and sticky overflow/underflow flags.
module sync_stage_fifo #(
  parameter int WID   = 32,
  parameter int DEPTH = 4,
  parameter int AFULL = DEPTH - 1
) (
  input  logic              clk,
  input  logic              rst,
  sync_stage_fifo_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WID-1:0] mem [DEPTH];
  logic [PW-1:0]  wptr_reg, wptr_next;
  logic [PW-1:0]  rptr_reg, rptr_next;
  logic [CW-1:0]  count_reg, count_next;
  logic           ovf_reg, ovf_next;
  logic           udf_reg, udf_next;

  logic empty, full, racc, wacc;

  // Flags come only from the registered count, never from the requests.
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

  // A full buffer still takes a write when a read frees a slot in the same cycle.
  assign racc = bus.readx && !empty;
  assign wacc = bus.writex && (!full || racc);

  always_comb begin
    wptr_next = wptr_reg;
    rptr_next = rptr_reg;
    if (wacc) wptr_next = wptr_reg + PW'(1);
    if (racc) rptr_next = rptr_reg + PW'(1);
  end

  always_comb begin
    count_next = count_reg;
    case ({wacc, racc})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Clearing wins over a coincident error event; that event is dropped.
  always_comb begin
    ovf_next = ovf_reg;
    udf_next = udf_reg;
    if (bus.clr_err) begin
      ovf_next = 1'b0;
      udf_next = 1'b0;
    end else begin
      if (bus.writex && !wacc) ovf_next = 1'b1;
      if (bus.readx && empty)  udf_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      udf_reg   <= 1'b0;
    end else begin
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      udf_reg   <= udf_next;
    end
  end

  // Storage is deliberately not reset; a write in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wacc) mem[wptr_reg] <= bus.wdata;
  end

  assign bus.rdata   = mem[rptr_reg];
  assign bus.rempty  = empty;
  assign bus.wfull   = full;
  assign bus.afull   = (count_reg >= CW'(AFULL));
  assign bus.count   = count_reg;
  assign bus.ovf_err = ovf_reg;
  assign bus.udf_err = udf_reg;
endmodule
